// File: rtl/usb_buffer_pkg.sv
// usb_buffer_pkg
//   Shared definitions for the USB endpoint buffer arbiter.
//   - DEPTH_DEF / AW_DEF : default FIFO depth in bytes and its address width.
//   - req_src_t          : request sources. The encoding doubles as the bit
//                          index of each source in the request/grant vectors.
//   - PRIO_ORDER         : sources listed from highest to lowest priority.
//   - src_is_push        : true for the two sources that write the FIFO.
package usb_buffer_pkg;

  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned AW_DEF    = 6;
  localparam int unsigned NUM_SRC   = 4;

  typedef enum logic [1:0] {
    SRC_RX_STORE  = 2'd0,
    SRC_TX_GET    = 2'd1,
    SRC_AHB_STORE = 2'd2,
    SRC_AHB_GET   = 2'd3
  } req_src_t;

  // The USB side comes first because it has bit-timing deadlines.
  localparam req_src_t PRIO_ORDER [NUM_SRC] = '{SRC_RX_STORE, SRC_TX_GET,
                                               SRC_AHB_STORE, SRC_AHB_GET};

  function automatic logic src_is_push(input req_src_t s);
    return (s == SRC_RX_STORE) || (s == SRC_AHB_STORE);
  endfunction

endpackage

// File: rtl/buffer_prio_arb.sv
// buffer_prio_arb
//   Four-request fixed-priority arbiter, purely combinational.
//   Ports:
//     req [NUM_SRC-1:0] in  : pending requests, bit index = req_src_t value.
//     gnt [NUM_SRC-1:0] out : one-hot grant (all zero when nothing pending).
module buffer_prio_arb
  import usb_buffer_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt
);

  // Walk from lowest to highest priority so the highest-priority request
  // present is the one left standing.
  always_comb begin
    gnt = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[PRIO_ORDER[i]]) begin
        gnt                = '0;
        gnt[PRIO_ORDER[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter
//   Controller for the USB endpoint's shared byte FIFO held in an external
//   single-port synchronous SRAM. Latches store/get pulses from the AHB side
//   and the USB side, grants one SRAM access per cycle by fixed priority,
//   maintains the circular pointers and occupancy, and returns read data.
//   Ports:
//     clk, rst (async, active-high), clear (sync flush)
//     store_tx_data/tx_data, get_rx_data -> rx_data/rx_data_valid    (AHB)
//     store_rx_packet_data/rx_packet_data,
//     get_tx_packet_data -> tx_packet_data/tx_packet_data_valid      (USB)
//     buffer_occ, overflow, underflow, req_drop                      (status)
//     mem_en, mem_we, mem_addr, mem_wdata, mem_rdata                 (SRAM)
module usb_buffer_arbiter
  import usb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          store_tx_data,
  input  logic [7:0]    tx_data,
  input  logic          get_rx_data,
  output logic [7:0]    rx_data,
  output logic          rx_data_valid,
  input  logic          store_rx_packet_data,
  input  logic [7:0]    rx_packet_data,
  input  logic          get_tx_packet_data,
  output logic [7:0]    tx_packet_data,
  output logic          tx_packet_data_valid,
  output logic [AW:0]   buffer_occ,
  output logic          overflow,
  output logic          underflow,
  output logic          req_drop,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  logic [NUM_SRC-1:0] req_pulse, gnt, gnt_eff;
  logic [NUM_SRC-1:0] pend_d, pend_q;
  logic [7:0]         rx_hold_d, rx_hold_q, ahb_hold_d, ahb_hold_q;
  logic [AW-1:0]      wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [AW:0]        occ_d, occ_q;
  logic               overflow_d, overflow_q, underflow_d, underflow_q;
  logic               req_drop_d, req_drop_q;
  logic               rd_vld_d, rd_vld_q, rd_to_tx_d, rd_to_tx_q;
  logic               rd_empty_d, rd_empty_q;
  logic [7:0]         rx_data_d, rx_data_q, tx_pkt_d, tx_pkt_q;
  logic               rx_vld_d, rx_vld_q, tx_vld_d, tx_vld_q;
  logic               full, empty, push_gnt, pop_gnt;

  always_comb begin
    req_pulse                = '0;
    req_pulse[SRC_RX_STORE]  = store_rx_packet_data;
    req_pulse[SRC_TX_GET]    = get_tx_packet_data;
    req_pulse[SRC_AHB_STORE] = store_tx_data;
    req_pulse[SRC_AHB_GET]   = get_rx_data;
  end

  buffer_prio_arb u_arb (
    .req (pend_q),
    .gnt (gnt)
  );

  assign full  = (occ_q == (AW+1)'(DEPTH));
  assign empty = (occ_q == '0);

  always_comb begin
    // clear suppresses the grant outright, so it also blocks any SRAM access.
    gnt_eff  = clear ? '0 : gnt;
    push_gnt = gnt_eff[SRC_RX_STORE] | gnt_eff[SRC_AHB_STORE];
    pop_gnt  = gnt_eff[SRC_TX_GET]   | gnt_eff[SRC_AHB_GET];

    mem_we    = push_gnt && !full;
    mem_en    = mem_we || (pop_gnt && !empty);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_we) begin
      mem_addr  = wr_ptr_q;
      mem_wdata = gnt_eff[SRC_RX_STORE] ? rx_hold_q : ahb_hold_q;
    end else if (mem_en) begin
      mem_addr  = rd_ptr_q;
    end

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    overflow_d  = overflow_q  | (push_gnt && full);
    underflow_d = underflow_q | (pop_gnt && empty);
    req_drop_d  = req_drop_q  | (|(req_pulse & pend_q));
    pend_d      = (pend_q & ~gnt_eff) | (req_pulse & ~pend_q);
    rx_hold_d   = rx_hold_q;
    ahb_hold_d  = ahb_hold_q;
    if (req_pulse[SRC_RX_STORE] && !pend_q[SRC_RX_STORE] && !clear)
      rx_hold_d = rx_packet_data;
    if (req_pulse[SRC_AHB_STORE] && !pend_q[SRC_AHB_STORE] && !clear)
      ahb_hold_d = tx_data;

    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      occ_d    = occ_q + (AW+1)'(1);
    end else if (mem_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      occ_d    = occ_q - (AW+1)'(1);
    end

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      req_drop_d  = 1'b0;
      pend_d      = '0;
    end

    // Read return: one cycle to get SRAM data, one to register it. A read
    // already in flight completes even if clear arrives meanwhile.
    rd_vld_d   = pop_gnt;
    rd_to_tx_d = gnt_eff[SRC_TX_GET];
    rd_empty_d = empty;
    rx_vld_d   = rd_vld_q && !rd_to_tx_q;
    tx_vld_d   = rd_vld_q &&  rd_to_tx_q;
    rx_data_d  = rx_data_q;
    tx_pkt_d   = tx_pkt_q;
    if (rx_vld_d) rx_data_d = rd_empty_q ? 8'h00 : mem_rdata;
    if (tx_vld_d) tx_pkt_d  = rd_empty_q ? 8'h00 : mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      req_drop_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_to_tx_q  <= 1'b0;
      rd_empty_q  <= 1'b0;
      rx_data_q   <= '0;
      tx_pkt_q    <= '0;
      rx_vld_q    <= 1'b0;
      tx_vld_q    <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      req_drop_q  <= req_drop_d;
      rd_vld_q    <= rd_vld_d;
      rd_to_tx_q  <= rd_to_tx_d;
      rd_empty_q  <= rd_empty_d;
      rx_data_q   <= rx_data_d;
      tx_pkt_q    <= tx_pkt_d;
      rx_vld_q    <= rx_vld_d;
      tx_vld_q    <= tx_vld_d;
    end
  end

  // Write-data holding registers are only consumed under a pending flag,
  // so they need no reset.
  always_ff @(posedge clk) begin
    rx_hold_q  <= rx_hold_d;
    ahb_hold_q <= ahb_hold_d;
  end

  assign rx_data              = rx_data_q;
  assign rx_data_valid        = rx_vld_q;
  assign tx_packet_data       = tx_pkt_q;
  assign tx_packet_data_valid = tx_vld_q;
  assign buffer_occ           = occ_q;
  assign overflow             = overflow_q;
  assign underflow            = underflow_q;
  assign req_drop             = req_drop_q;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
module tb_usb_buffer_arbiter;

  logic       clk = 1'b0;
  logic       rst, clear;
  logic       store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data;
  logic [7:0] tx_data, rx_packet_data, rx_data, tx_packet_data, mem_wdata, mem_rdata;
  logic       rx_data_valid, tx_packet_data_valid;
  logic [6:0] buffer_occ;
  logic       overflow, underflow, req_drop, mem_en, mem_we;
  logic [5:0] mem_addr;
  logic [7:0] sram [64];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  usb_buffer_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .rx_data_valid        (rx_data_valid),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .tx_packet_data_valid (tx_packet_data_valid),
    .buffer_occ           (buffer_occ),
    .overflow             (overflow),
    .underflow            (underflow),
    .req_drop             (req_drop),
    .mem_en               (mem_en),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata)
  );

  // Single-port synchronous SRAM: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ahb(input logic [7:0] b);
    store_tx_data = 1'b1; tx_data = b;
    tick();
    store_tx_data = 1'b0; tx_data = 8'h00;
    tick();
  endtask

  task automatic push_rx(input logic [7:0] b);
    store_rx_packet_data = 1'b1; rx_packet_data = b;
    tick();
    store_rx_packet_data = 1'b0; rx_packet_data = 8'h00;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({rx_data, rx_data_valid, tx_packet_data, tx_packet_data_valid} !== 18'h0) begin
      failures++;
      $display("FAIL reset_data got=%h expected=0", {rx_data, rx_data_valid, tx_packet_data, tx_packet_data_valid});
    end
    checks++;
    if ({buffer_occ, overflow, underflow, req_drop, mem_en, mem_we, mem_addr, mem_wdata} !== 26'h0) begin
      failures++;
      $display("FAIL reset_status got=%h expected=0", {buffer_occ, overflow, underflow, req_drop, mem_en, mem_we, mem_addr, mem_wdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push_pop();
    store_tx_data = 1'b1; tx_data = 8'hA5;
    tick();
    store_tx_data = 1'b0; tx_data = 8'h00;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 6'd0, 8'hA5}) begin
      failures++;
      $display("FAIL pp_write got=%h expected=%h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 6'd0, 8'hA5});
    end
    checks++;
    if (buffer_occ !== 7'd0) begin failures++; $display("FAIL pp_occ_grant got=%0d expected=0", buffer_occ); end
    tick();
    checks++;
    if (buffer_occ !== 7'd1) begin failures++; $display("FAIL pp_occ_one got=%0d expected=1", buffer_occ); end
    get_tx_packet_data = 1'b1;
    tick();
    get_tx_packet_data = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL pp_read got=%h expected=%h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 6'd0});
    end
    tick();
    checks++;
    if ({buffer_occ, tx_packet_data_valid} !== {7'd0, 1'b0}) begin
      failures++;
      $display("FAIL pp_g1 got occ=%0d vld=%b expected occ=0 vld=0", buffer_occ, tx_packet_data_valid);
    end
    tick();
    checks++;
    if ({tx_packet_data_valid, tx_packet_data} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL pp_strobe got vld=%b data=%h expected vld=1 data=a5", tx_packet_data_valid, tx_packet_data);
    end
    tick();
    checks++;
    if ({tx_packet_data_valid, tx_packet_data} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL pp_hold got vld=%b data=%h expected vld=0 data=a5", tx_packet_data_valid, tx_packet_data);
    end
  endtask

  // Entry state: wr_ptr=1, rd_ptr=1, occ=0.
  task automatic test_simultaneous();
    logic [14:0] exp_mem [4];
    exp_mem[0] = {1'b1, 6'd3, 8'h33};
    exp_mem[1] = {1'b0, 6'd1, 8'h00};
    exp_mem[2] = {1'b1, 6'd4, 8'h44};
    exp_mem[3] = {1'b0, 6'd2, 8'h00};
    push_rx(8'h11);
    push_rx(8'h22);
    checks++;
    if (buffer_occ !== 7'd2) begin failures++; $display("FAIL sim_preload got=%0d expected=2", buffer_occ); end
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h33;
    get_tx_packet_data   = 1'b1;
    store_tx_data        = 1'b1; tx_data = 8'h44;
    get_rx_data          = 1'b1;
    tick();
    store_rx_packet_data = 1'b0; get_tx_packet_data = 1'b0;
    store_tx_data        = 1'b0; get_rx_data = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, exp_mem[c]}) begin
        failures++;
        $display("FAIL sim_grant%0d got=%h expected=%h", c, {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, exp_mem[c]});
      end
      if (c < 3) tick();
    end
    checks++;
    if ({tx_packet_data_valid, tx_packet_data, buffer_occ} !== {1'b1, 8'h11, 7'd3}) begin
      failures++;
      $display("FAIL sim_tx_ret got vld=%b data=%h occ=%0d expected vld=1 data=11 occ=3", tx_packet_data_valid, tx_packet_data, buffer_occ);
    end
    tick();
    checks++;
    if ({mem_en, buffer_occ} !== {1'b0, 7'd2}) begin
      failures++;
      $display("FAIL sim_final got en=%b occ=%0d expected en=0 occ=2", mem_en, buffer_occ);
    end
    tick();
    checks++;
    if ({rx_data_valid, rx_data} !== {1'b1, 8'h22}) begin
      failures++;
      $display("FAIL sim_rx_ret got vld=%b data=%h expected vld=1 data=22", rx_data_valid, rx_data);
    end
  endtask

  // Entry state: wr_ptr=5, rd_ptr=3, occ=2, sram[3]=33.
  task automatic test_duplicate();
    int pops = 0;
    int strobes = 0;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h55;
    store_tx_data        = 1'b1; tx_data = 8'h66;
    get_rx_data          = 1'b1;
    tick();
    store_rx_packet_data = 1'b0; store_tx_data = 1'b0;
    checks++;
    if (req_drop !== 1'b0) begin failures++; $display("FAIL dup_before got=%b expected=0", req_drop); end
    tick();
    get_rx_data = 1'b0;
    checks++;
    if (req_drop !== 1'b1) begin failures++; $display("FAIL dup_flag got=%b expected=1", req_drop); end
    for (int c = 0; c < 6; c++) begin
      if (mem_en && !mem_we) begin
        pops++;
        checks++;
        if (mem_addr !== 6'd3) begin failures++; $display("FAIL dup_addr got=%0d expected=3", mem_addr); end
      end
      if (rx_data_valid) strobes++;
      tick();
    end
    checks++;
    if ({pops, strobes} !== {32'd1, 32'd1}) begin
      failures++;
      $display("FAIL dup_single got pops=%0d strobes=%0d expected pops=1 strobes=1", pops, strobes);
    end
    checks++;
    if ({rx_data, buffer_occ} !== {8'h33, 7'd3}) begin
      failures++;
      $display("FAIL dup_data got data=%h occ=%0d expected data=33 occ=3", rx_data, buffer_occ);
    end
  endtask

  task automatic test_clear();
    int activity = 0;
    for (int i = 0; i < 7; i++) push_ahb(8'(8'h80 + i));
    checks++;
    if (buffer_occ !== 7'd10) begin failures++; $display("FAIL clr_preload got=%0d expected=10", buffer_occ); end
    get_tx_packet_data = 1'b1; get_rx_data = 1'b1;
    tick();
    get_tx_packet_data = 1'b0; get_rx_data = 1'b0;
    clear = 1'b1; store_tx_data = 1'b1; tx_data = 8'hEE;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL clr_no_access got=%b expected=0", mem_en); end
    tick();
    clear = 1'b0; store_tx_data = 1'b0;
    checks++;
    if ({buffer_occ, overflow, underflow, req_drop} !== 10'h0) begin
      failures++;
      $display("FAIL clr_state got occ=%0d ovf=%b udf=%b drop=%b expected all 0", buffer_occ, overflow, underflow, req_drop);
    end
    for (int c = 0; c < 5; c++) begin
      if (mem_en || rx_data_valid || tx_packet_data_valid) activity++;
      tick();
    end
    checks++;
    if (activity !== 0) begin failures++; $display("FAIL clr_no_grants got=%0d expected=0", activity); end
  endtask

  // Entry state: pointers and occupancy zero.
  task automatic test_wrap();
    int bad = 0;
    for (int i = 0; i < 64; i++) push_ahb(8'(i) ^ 8'h3C);
    checks++;
    if ({buffer_occ, overflow} !== {7'd64, 1'b0}) begin
      failures++;
      $display("FAIL wrap_full got occ=%0d ovf=%b expected occ=64 ovf=0", buffer_occ, overflow);
    end
    store_tx_data = 1'b1; tx_data = 8'hFF;
    tick();
    store_tx_data = 1'b0;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL wrap_full_access got=%b expected=0", mem_en); end
    tick();
    checks++;
    if ({buffer_occ, overflow} !== {7'd64, 1'b1}) begin
      failures++;
      $display("FAIL wrap_overflow got occ=%0d ovf=%b expected occ=64 ovf=1", buffer_occ, overflow);
    end
    for (int i = 0; i < 64; i++) begin
      get_rx_data = 1'b1;
      tick();
      get_rx_data = 1'b0;
      if ({mem_en, mem_addr} !== {1'b1, 6'(i)}) bad++;
      tick(); tick();
      checks++;
      if ({rx_data_valid, rx_data} !== {1'b1, 8'(i) ^ 8'h3C}) begin
        failures++;
        $display("FAIL wrap_pop%0d got vld=%b data=%h expected vld=1 data=%h", i, rx_data_valid, rx_data, 8'(i) ^ 8'h3C);
      end
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL wrap_pop_addr got=%0d bad expected=0", bad); end
    checks++;
    if ({buffer_occ, underflow} !== {7'd0, 1'b0}) begin
      failures++;
      $display("FAIL wrap_empty got occ=%0d udf=%b expected occ=0 udf=0", buffer_occ, underflow);
    end
    get_rx_data = 1'b1;
    tick();
    get_rx_data = 1'b0;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL wrap_empty_access got=%b expected=0", mem_en); end
    tick(); tick();
    checks++;
    if ({rx_data_valid, rx_data, underflow, buffer_occ} !== {1'b1, 8'h00, 1'b1, 7'd0}) begin
      failures++;
      $display("FAIL wrap_underflow got vld=%b data=%h udf=%b occ=%0d expected vld=1 data=00 udf=1 occ=0", rx_data_valid, rx_data, underflow, buffer_occ);
    end
    store_tx_data = 1'b1; tx_data = 8'h77;
    tick();
    store_tx_data = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 6'd0}) begin
      failures++;
      $display("FAIL wrap_ptr0 got=%h expected=%h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 6'd0});
    end
    tick();
  endtask

  // Entry state: occ=1, tx_packet_data still holds 11 from earlier.
  task automatic test_reset_mid_read();
    get_tx_packet_data = 1'b1;
    tick();
    get_tx_packet_data = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({buffer_occ, tx_packet_data, tx_packet_data_valid, mem_en} !== 17'h0) begin
      failures++;
      $display("FAIL rmr_immediate got occ=%0d data=%h vld=%b en=%b expected all 0", buffer_occ, tx_packet_data, tx_packet_data_valid, mem_en);
    end
    tick();
    checks++;
    if (tx_packet_data_valid !== 1'b0) begin failures++; $display("FAIL rmr_no_strobe got=%b expected=0", tx_packet_data_valid); end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({rx_data, rx_data_valid, tx_packet_data, tx_packet_data_valid, buffer_occ,
         overflow, underflow, req_drop, mem_en, mem_we, mem_addr, mem_wdata} !== 44'h0) begin
      failures++;
      $display("FAIL rmr_release got=%h expected=0", {rx_data, rx_data_valid, tx_packet_data, tx_packet_data_valid,
               buffer_occ, overflow, underflow, req_drop, mem_en, mem_we, mem_addr, mem_wdata});
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    store_tx_data = 1'b0; get_rx_data = 1'b0;
    store_rx_packet_data = 1'b0; get_tx_packet_data = 1'b0;
    tx_data = 8'h00; rx_packet_data = 8'h00;
    test_reset();
    test_push_pop();
    test_simultaneous();
    test_duplicate();
    test_clear();
    test_wrap();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_buffer_arbiter.md
# usb_buffer_arbiter

Controller for the USB endpoint's shared 64-byte data FIFO, built on an external single-port synchronous SRAM. It accepts single-cycle store/get pulses from the AHB-Lite slave side (`store_tx_data`, `get_rx_data`) and from the USB side (`store_rx_packet_data`, `get_tx_packet_data`). Each request is latched, the requests are arbitrated to one SRAM access per cycle, the circular pointers and occupancy are maintained, and read data is returned to the requester. It sits between the AHB slave, the RX/TX protocol engines, and the SRAM macro.

## Interface
- `DEPTH`, 64, FIFO depth in bytes; power of two.
- `AW`, 6, address width, log2(`DEPTH`).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous flush, from the AHB clear register.
- `store_tx_data` in 1: AHB-side push pulse.
- `tx_data` in 8: AHB-side push byte, sampled with `store_tx_data`.
- `get_rx_data` in 1: AHB-side pop pulse.
- `rx_data` out 8: AHB-side pop result.
- `rx_data_valid` out 1: one-cycle strobe indicating `rx_data` is updated.
- `store_rx_packet_data` in 1: USB RX push pulse.
- `rx_packet_data` in 8: USB RX push byte.
- `get_tx_packet_data` in 1: USB TX pop pulse.
- `tx_packet_data` out 8: USB TX pop result.
- `tx_packet_data_valid` out 1: one-cycle strobe indicating `tx_packet_data` is updated.
- `buffer_occ` out AW+1: byte count, 0..64.
- `overflow` out 1: sticky; a push was attempted while full.
- `underflow` out 1: sticky; a pop was attempted while empty.
- `req_drop` out 1: sticky; a request pulse arrived while the same source was already pending.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out 8: SRAM port.
- `mem_rdata` in 8: SRAM read data, valid the cycle after the read enable.

## Operation
- Four pending flags, one per source, plus two 8-bit write-data holding registers.
  - A request pulse sets its source's flag and captures its data.
  - A pulse that arrives while its flag is already set is ignored and sets `req_drop`.
- Fixed-priority grant, at most one per cycle: RX store > TX get > AHB store > AHB get.
  - The USB side has priority because it has bit-timing deadlines.
  - Granting a source clears its flag in the same cycle.
- Push grant:
  - Not full: write `mem_addr=wr_ptr`, increment `wr_ptr` and `buffer_occ`.
  - Full: no SRAM access, no pointer change, set `overflow`.
- Pop grant:
  - Not empty: read `mem_addr=rd_ptr`, increment `rd_ptr`, decrement `buffer_occ`.
  - Empty: no SRAM access; the destination register loads `0x00`, its valid strobe still fires, and `underflow` is set.
- Pointers are AW bits wide and wrap from 63 to 0. `buffer_occ` never exceeds `DEPTH` and never goes below 0.
- `clear` overrides all other activity in its cycle. It zeroes the pointers, `buffer_occ`, pending flags and sticky flags, and issues no SRAM access. A request pulse in the same cycle as `clear` is discarded.
- Reset values: all outputs are 0; `mem_*` are inactive.

## Timing
- Request pulse in cycle N → pending flag set from N+1.
- Best-case grant is in N+1, with `mem_*` driven combinationally in the grant cycle.
- Pointer and occupancy updates are registered at the end of the grant cycle G, so `buffer_occ` changes in G+1.
- Pop read latency:
  - `mem_rdata` is valid in G+1.
  - It is registered into `rx_data` or `tx_packet_data` at the end of G+1.
  - The valid strobe is high in G+2, so the uncontended pulse-to-data latency is 3 cycles.
- `rx_data` and `tx_packet_data` hold their value until the next pop of the same source.
- An empty pop still follows the G+2 strobe timing.
- A push and a pop cannot share a cycle. A push granted in G is readable by a pop granted in G+1, because the SRAM write commits at the end of G.
- Reset asserted mid-operation clears all state immediately. An in-flight read data return is lost and no strobe fires.
- If `clear` is asserted in G+1 of a pop, the data register still loads and the strobe still fires, but the pointers read as reset.

## Structure
- Package `usb_buffer_pkg` holds:
  - `DEPTH` and `AW` defaults.
  - `req_src_t` enum {`SRC_RX_STORE`, `SRC_TX_GET`, `SRC_AHB_STORE`, `SRC_AHB_GET`}.
  - A priority-order constant.
- Sub-module `buffer_prio_arb`: a 4-request fixed-priority arbiter with one-hot grant output.
- The pointers, occupancy, flags and return registers live in the top module.

## Test plan
- **Push then pop:** AHB stores `0xA5`, then RX later issues a TX get → `tx_packet_data=0xA5`, strobe 3 cycles after the get pulse, `buffer_occ` goes 0→1→0.
- **Simultaneous pulses:** all four sources pulse in the same cycle with the FIFO holding 2 bytes → grants in 4 consecutive cycles in the order RX store, TX get, AHB store, AHB get; final `buffer_occ=2`.
- **Wrap-around:** 64 pushes, then a 65th → `buffer_occ=64`, `overflow=1`. Then 64 pops return the bytes in order, the pointers wrap to 0, and a 65th pop gives `0x00` with `underflow=1`.
- **Duplicate pulse:** AHB get pulsed twice while still pending behind an RX store stream → a single pop, `req_drop=1`.
- **Clear during pending:** `clear` asserted with 10 bytes stored and 2 requests pending → `buffer_occ=0`, no grants follow, sticky flags cleared.
- **Reset mid-read:** `rst` asserted in G+1 of a pop → no strobe; all outputs 0 on release.
